// File: rtl/key_beep_driver.sv
// Turns each debounced key press into BEEP_NUM tone bursts on a passive buzzer; registered outputs, 1-cycle start latency.
// Define KEY_BEEP_RETRIGGER_EN to let a press during an active pattern restart it instead of being ignored.
module key_beep_driver #(
    parameter logic [15:0] TONE_HALF = 16'd25_000,
    parameter logic [23:0] ON_CYC    = 24'd5_000_000,
    parameter logic [23:0] OFF_CYC   = 24'd5_000_000,
    parameter logic [3:0]  BEEP_NUM  = 4'd3
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_flt,
    output logic beep,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] tone_cnt_q, tone_cnt_d;
    logic [23:0] dur_cnt_q, dur_cnt_d;
    logic [3:0]  rep_cnt_q, rep_cnt_d;
    logic        beep_q, beep_d;
    logic        busy_q;
    logic        done_q, done_d;
    logic        key_prev_q;
    logic        armed_q;
    logic        press;
    logic        start;

    // armed_q masks the first cycle after reset so a key already held low never looks like a fresh press
    assign press = armed_q & key_prev_q & ~key_flt;

`ifdef KEY_BEEP_RETRIGGER_EN
    assign start = press & ~done_q;
`else
    assign start = press & (state_q == S_IDLE) & ~done_q;
`endif

    always_comb begin
        state_d    = state_q;
        tone_cnt_d = tone_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        beep_d     = beep_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                beep_d = 1'b0;
            end
            S_ON: begin
                if (dur_cnt_q == ON_CYC - 24'd1) begin
                    beep_d     = 1'b0;
                    dur_cnt_d  = 24'd0;
                    tone_cnt_d = 16'd0;
                    if (rep_cnt_q == BEEP_NUM - 4'd1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    dur_cnt_d = dur_cnt_q + 24'd1;
                    if (tone_cnt_q == TONE_HALF - 16'd1) begin
                        beep_d     = ~beep_q;
                        tone_cnt_d = 16'd0;
                    end else begin
                        tone_cnt_d = tone_cnt_q + 16'd1;
                    end
                end
            end
            S_GAP: begin
                beep_d = 1'b0;
                if (dur_cnt_q == OFF_CYC - 24'd1) begin
                    state_d    = S_ON;
                    beep_d     = 1'b1;
                    rep_cnt_d  = rep_cnt_q + 4'd1;
                    tone_cnt_d = 16'd0;
                    dur_cnt_d  = 24'd0;
                end else begin
                    dur_cnt_d = dur_cnt_q + 24'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                beep_d  = 1'b0;
            end
        endcase

        // A (re)start overrides whatever the current state decided, including completion
        if (start) begin
            state_d    = S_ON;
            beep_d     = 1'b1;
            tone_cnt_d = 16'd0;
            dur_cnt_d  = 24'd0;
            rep_cnt_d  = 4'd0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            tone_cnt_q <= 16'd0;
            dur_cnt_q  <= 24'd0;
            rep_cnt_q  <= 4'd0;
            beep_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            key_prev_q <= 1'b1;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tone_cnt_q <= tone_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            beep_q     <= beep_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= done_d;
            key_prev_q <= key_flt;
            armed_q    <= 1'b1;
        end
    end

    assign beep = beep_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_key_beep_driver.sv
// Bench for key_beep_driver: a BEEP_NUM=2 instance driven by a scenario table and a BEEP_NUM=1 instance.
// Per-cycle expectations come from a timing-formula model and are queued, then popped on the falling edge.
module tb_key_beep_driver;

    localparam int TH  = 4;
    localparam int ON  = 20;
    localparam int OFF = 10;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;
    logic key_a     = 1'b0;
    logic key_b     = 1'b0;
    logic beep_a, busy_a, done_a;
    logic beep_b, busy_b, done_b;

    always #5 sys_clk = ~sys_clk;

    key_beep_driver #(.TONE_HALF(16'd4), .ON_CYC(24'd20), .OFF_CYC(24'd10), .BEEP_NUM(4'd2)) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_flt(key_a),
        .beep(beep_a), .busy(busy_a), .done(done_a));

    key_beep_driver #(.TONE_HALF(16'd4), .ON_CYC(24'd20), .OFF_CYC(24'd10), .BEEP_NUM(4'd1)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_flt(key_b),
        .beep(beep_b), .busy(busy_b), .done(done_b));

    typedef struct packed {
        logic [2:0] a;   // {beep, busy, done}
        logic [2:0] b;
    } exp_t;

    typedef struct {
        int p2;      // offset of second press from first press (0 = none)
        int s2;      // offset at which a restarted pattern begins (0 = no restart)
        int busy;
        int dones;
        int highs;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   a_s1 = -1, a_s2 = -1, b_s1 = -1;
    int   cnt_busy_a, cnt_done_a, cnt_high_a;
    int   cnt_busy_b, cnt_done_b, cnt_high_b;
    logic prev_beep_a, prev_beep_b;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Expected {beep,busy,done} i cycles into a pattern with num bursts
    function automatic logic [2:0] pat(input int i, input int num);
        int len;
        int pos;
        len = num * ON + (num - 1) * OFF;
        if (i < 0 || i > len) return 3'b000;
        if (i == len) return 3'b001;
        pos = i % (ON + OFF);
        return {((pos < ON) && ((pos % (2 * TH)) < TH)) ? 1'b1 : 1'b0, 1'b1, 1'b0};
    endfunction

    function automatic logic [2:0] exp_of(input int k, input int s1, input int s2, input int num);
        if (s2 >= 0 && k >= s2) return pat(k - s2, num);
        if (s1 >= 0) return pat(k - s1, num);
        return 3'b000;
    endfunction

    task automatic tick(input logic ka, input logic kb);
        @(posedge sys_clk);
        #1;
        key_a = ka;
        key_b = kb;
        cyc++;
        sb.push_back({exp_of(cyc, a_s1, a_s2, 2), exp_of(cyc, b_s1, -1, 1)});
    endtask

    task automatic clear_counts();
        cnt_busy_a = 0; cnt_done_a = 0; cnt_high_a = 0; prev_beep_a = 1'b0;
        cnt_busy_b = 0; cnt_done_b = 0; cnt_high_b = 0; prev_beep_b = 1'b0;
    endtask

    always @(negedge sys_clk) begin
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("a.beep", int'(beep_a), int'(e.a[2]));
            check("a.busy", int'(busy_a), int'(e.a[1]));
            check("a.done", int'(done_a), int'(e.a[0]));
            check("b.beep", int'(beep_b), int'(e.b[2]));
            check("b.busy", int'(busy_b), int'(e.b[1]));
            check("b.done", int'(done_b), int'(e.b[0]));
            if (busy_a) cnt_busy_a++;
            if (done_a) cnt_done_a++;
            if (beep_a && !prev_beep_a) cnt_high_a++;
            prev_beep_a = beep_a;
            if (busy_b) cnt_busy_b++;
            if (done_b) cnt_done_b++;
            if (beep_b && !prev_beep_b) cnt_high_b++;
            prev_beep_b = beep_b;
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        int c0;
        tick(1'b1, 1'b1);
        clear_counts();
        c0   = cyc + 1;
        a_s1 = c0 + 1;
        a_s2 = (v.s2 > 0) ? c0 + v.s2 : -1;
        tick(1'b0, 1'b1);
        for (int r = 1; r <= 110; r++)
            tick((v.p2 > 0 && r == v.p2 - 1) ? 1'b1 : 1'b0, 1'b1);
        @(negedge sys_clk);
        #1;
        check($sformatf("vec%0d.busy_cycles", idx), cnt_busy_a, v.busy);
        check($sformatf("vec%0d.done_pulses", idx), cnt_done_a, v.dones);
        check($sformatf("vec%0d.high_phases", idx), cnt_high_a, v.highs);
        a_s1 = -1;
        a_s2 = -1;
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{0, 0, 50, 1, 6};
`ifdef KEY_BEEP_RETRIGGER_EN
        vecs[1] = '{15, 16, 65, 1, 8};
        vecs[2] = '{50, 51, 100, 1, 11};
`else
        vecs[1] = '{15, 0, 50, 1, 6};
        vecs[2] = '{50, 0, 50, 1, 6};
`endif
        vecs[3] = '{51, 0, 50, 1, 6};
        vecs[4] = '{52, 53, 100, 2, 12};

        // Reset with both keys held low; release must not start a pattern
        #2 sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst.beep_a", int'(beep_a), 0);
        check("rst.busy_a", int'(busy_a), 0);
        check("rst.done_a", int'(done_a), 0);
        check("rst.busy_b", int'(busy_b), 0);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        clear_counts();
        for (int i = 0; i < 100; i++) tick(1'b0, 1'b0);
        @(negedge sys_clk);
        #1;
        check("held_low.busy_cycles", cnt_busy_a + cnt_busy_b, 0);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Asynchronous reset while in the gap between bursts
        begin
            int c0;
            tick(1'b1, 1'b1);
            c0   = cyc + 1;
            a_s1 = c0 + 1;
            tick(1'b0, 1'b1);
            for (int r = 1; r <= 25; r++) tick(1'b0, 1'b1);
            @(negedge sys_clk);
            #1 sys_rst_n = 1'b0;
            #1;
            check("gap_rst.beep", int'(beep_a), 0);
            check("gap_rst.busy", int'(busy_a), 0);
            check("gap_rst.done", int'(done_a), 0);
            a_s1 = -1;
            repeat (2) @(posedge sys_clk);
            #1 sys_rst_n = 1'b1;
            clear_counts();
            for (int r = 0; r < 30; r++) tick(1'b0, 1'b1);
            @(negedge sys_clk);
            #1;
            check("gap_rst.after_busy", cnt_busy_a, 0);
        end

        // Single-burst instance
        begin
            int c0;
            tick(1'b1, 1'b1);
            clear_counts();
            c0   = cyc + 1;
            b_s1 = c0 + 1;
            tick(1'b1, 1'b0);
            for (int r = 1; r <= 30; r++) tick(1'b1, 1'b0);
            @(negedge sys_clk);
            #1;
            check("num1.busy_cycles", cnt_busy_b, 20);
            check("num1.done_pulses", cnt_done_b, 1);
            check("num1.high_phases", cnt_high_b, 3);
            b_s1 = -1;
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
